// File: rtl/multi_ultrasonic_ctrl_pkg.sv
// Shared types and constants for the multi-channel ultrasonic ranging controller.
//   state_t   : sequencing FSM states
//   DIST_W    : width of one channel's distance result (mm)
//   ch_idx_w  : register width needed to index NUM_CH channels (capped at 3)
package multi_ultrasonic_pkg;

    localparam int DIST_W       = 16;
    localparam int CH_IDX_MAX_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        UPDATE,
        HOLDOFF
    } state_t;

    function automatic int ch_idx_w(input int num_ch);
        if (num_ch <= 2)
            return 1;
        else if (num_ch <= 4)
            return 2;
        else
            return CH_IDX_MAX_W;
    endfunction

endpackage

// File: rtl/multi_ultrasonic_ctrl_if.sv
// Pin/result bundle between the sensor side, the navigation FSM and the
// ultrasonic controller.
//   enable, obst_thresh_mm, echo_rx : into the controller
//   trig, distance_out, op, timeout,
//   meas_valid, meas_ch             : out of the controller
// slave  = the controller, master = the surrounding system.
interface multi_ultrasonic_ctrl_if
    import multi_ultrasonic_pkg::*;
#(
    parameter int NUM_CH = 3
);
    logic                       enable;
    logic [DIST_W-1:0]          obst_thresh_mm;
    logic [NUM_CH-1:0]          echo_rx;
    logic [NUM_CH-1:0]          trig;
    logic [DIST_W*NUM_CH-1:0]   distance_out;
    logic [NUM_CH-1:0]          op;
    logic [NUM_CH-1:0]          timeout;
    logic                       meas_valid;
    logic [CH_IDX_MAX_W-1:0]    meas_ch;

    modport master (
        output enable, obst_thresh_mm, echo_rx,
        input  trig, distance_out, op, timeout, meas_valid, meas_ch
    );

    modport slave (
        input  enable, obst_thresh_mm, echo_rx,
        output trig, distance_out, op, timeout, meas_valid, meas_ch
    );

endinterface

// File: rtl/multi_ultrasonic_ctrl_echo_timer.sv
// Echo pulse timer shared by all channels (the top muxes in the selected
// synchronized echo).
//   clear     : hold counters at their start values (asserted during TRIG)
//   wait_en   : waiting for echo rise; runs the no-echo timeout
//   meas_en   : echo is high; runs prescaler, mm counter and stuck-echo timeout
//   echo      : synchronized echo of the selected channel
//   started   : rising edge seen while waiting
//   done      : falling edge seen while measuring
//   timed_out : timeout expired in either phase
//   mm        : floor(high cycles / CYCLES_PER_MM), saturating
module ultrasonic_echo_timer
    import multi_ultrasonic_pkg::*;
#(
    parameter int CYCLES_PER_MM       = 294,
    parameter int ECHO_TIMEOUT_CYCLES = 1_500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wait_en,
    input  logic              meas_en,
    input  logic              echo,
    output logic              started,
    output logic              done,
    output logic              timed_out,
    output logic [DIST_W-1:0] mm
);

    localparam int PSW = $clog2(CYCLES_PER_MM + 1);
    localparam int TW  = $clog2(ECHO_TIMEOUT_CYCLES + 1);
    localparam logic [PSW-1:0] PS_LAST  = PSW'(CYCLES_PER_MM - 1);
    localparam logic [TW-1:0]  TMO_LOAD = TW'(ECHO_TIMEOUT_CYCLES - 1);

    logic              echo_prev;
    logic [PSW-1:0]    prescale;
    logic [TW-1:0]     tmo_cnt;
    logic [DIST_W-1:0] mm_cnt;
    logic              rise;
    logic              fall;
    logic              tmo_zero;
    logic              count_hi;

    assign rise     = echo & ~echo_prev;
    assign fall     = ~echo & echo_prev;
    assign tmo_zero = (tmo_cnt == '0);

    assign started   = wait_en & rise;
    assign done      = meas_en & fall;
    // While measuring, the high-cycle count may reach exactly the timeout;
    // only one more high cycle beyond that is a stuck echo.
    assign timed_out = (wait_en & ~rise & tmo_zero) | (meas_en & echo & tmo_zero);
    // The cycle the rise is detected already counts as the first high cycle.
    assign count_hi  = started | (meas_en & echo & ~tmo_zero);
    assign mm        = mm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_prev <= 1'b0;
            prescale  <= '0;
            tmo_cnt   <= TMO_LOAD;
            mm_cnt    <= '0;
        end else begin
            echo_prev <= echo;
            if (clear) begin
                prescale <= '0;
                tmo_cnt  <= TMO_LOAD;
                mm_cnt   <= '0;
            end else begin
                if (started)
                    tmo_cnt <= TMO_LOAD;
                else if ((wait_en || (meas_en && echo)) && !tmo_zero)
                    tmo_cnt <= tmo_cnt - TW'(1);

                if (count_hi) begin
                    if (prescale == PS_LAST) begin
                        prescale <= '0;
                        if (mm_cnt != '1)
                            mm_cnt <= mm_cnt + DIST_W'(1);
                    end else begin
                        prescale <= prescale + PSW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/multi_ultrasonic_ctrl.sv
// Round-robin controller for NUM_CH HC-SR04-class ultrasonic sensors.
// Each slot fires one trigger, times that channel's echo with the shared
// echo timer and stores distance / obstacle / timeout for the channel.
//   clk_50M, reset : 50 MHz clock, async active-high reset
//   bus (slave)    : enable, obst_thresh_mm, echo_rx in;
//                    trig, distance_out, op, timeout, meas_valid, meas_ch out
//
// state     | meaning
// IDLE      | scan stopped; counts STARTUP_CYCLES once enable is high
// TRIG      | trig[ch] high for TRIG_CYCLES; slot counter restarted
// WAIT_ECHO | waiting for a fresh rising edge on echo[ch]
// MEASURE   | echo[ch] high; shared timer accumulates mm
// UPDATE    | result registers written, meas_valid pulse
// HOLDOFF   | waits for slot end, then advances ch and re-triggers or idles
module multi_ultrasonic_ctrl
    import multi_ultrasonic_pkg::*;
#(
    parameter int NUM_CH              = 3,
    parameter int STARTUP_CYCLES      = 50,
    parameter int TRIG_CYCLES         = 500,
    parameter int CYCLES_PER_MM       = 294,
    parameter int ECHO_TIMEOUT_CYCLES = 1_500_000,
    parameter int SLOT_CYCLES         = 3_600_000
) (
    input logic                   clk_50M,
    input logic                   reset,
    multi_ultrasonic_ctrl_if.slave bus
);

    localparam int CHW = ch_idx_w(NUM_CH);
    localparam int PW  = $clog2(((STARTUP_CYCLES > TRIG_CYCLES) ? STARTUP_CYCLES : TRIG_CYCLES) + 1);
    localparam int SW  = $clog2(SLOT_CYCLES + 1);
    localparam logic [PW-1:0]     STARTUP_LOAD = PW'(STARTUP_CYCLES - 1);
    localparam logic [PW-1:0]     TRIG_LOAD    = PW'(TRIG_CYCLES - 1);
    localparam logic [SW-1:0]     SLOT_LOAD    = SW'(SLOT_CYCLES - 1);
    localparam logic [CHW-1:0]    CH_LAST      = CHW'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] TRIG_ONE     = NUM_CH'(1);

    state_t            state;
    logic [CHW-1:0]    ch;
    logic [CHW-1:0]    ch_next;
    logic [PW-1:0]     phase_cnt;
    logic [SW-1:0]     slot_rem;
    logic [NUM_CH-1:0] echo_meta;
    logic [NUM_CH-1:0] echo_sync;
    logic              echo_sel;
    logic              started;
    logic              done;
    logic              timed_out;
    logic [DIST_W-1:0] mm;
    logic              result_write;
    logic [DIST_W-1:0] res_dist;
    logic              res_op;

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            echo_meta <= '0;
            echo_sync <= '0;
        end else begin
            echo_meta <= bus.echo_rx;
            echo_sync <= echo_meta;
        end
    end

    assign echo_sel = echo_sync[ch];
    assign ch_next  = (ch == CH_LAST) ? '0 : ch + CHW'(1);

    ultrasonic_echo_timer #(
        .CYCLES_PER_MM       (CYCLES_PER_MM),
        .ECHO_TIMEOUT_CYCLES (ECHO_TIMEOUT_CYCLES)
    ) u_echo_timer (
        .clk       (clk_50M),
        .rst       (reset),
        .clear     (state == TRIG),
        .wait_en   (state == WAIT_ECHO),
        .meas_en   (state == MEASURE),
        .echo      (echo_sel),
        .started   (started),
        .done      (done),
        .timed_out (timed_out),
        .mm        (mm)
    );

    // The timer only raises done/timed_out in WAIT_ECHO or MEASURE, so either
    // one marks the edge into UPDATE. The threshold is sampled right here.
    assign result_write = done | timed_out;
    assign res_dist     = timed_out ? '0 : mm;
    assign res_op       = !timed_out && (mm != '0) && (mm <= bus.obst_thresh_mm);

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            ch               <= '0;
            phase_cnt        <= STARTUP_LOAD;
            slot_rem         <= '0;
            bus.trig         <= '0;
            bus.distance_out <= '0;
            bus.op           <= '0;
            bus.timeout      <= '0;
            bus.meas_valid   <= 1'b0;
            bus.meas_ch      <= '0;
        end else begin
            bus.meas_valid <= 1'b0;
            if (slot_rem != '0)
                slot_rem <= slot_rem - SW'(1);

            case (state)
                IDLE: begin
                    if (!bus.enable) begin
                        phase_cnt <= STARTUP_LOAD;
                    end else if (phase_cnt == '0) begin
                        state     <= TRIG;
                        bus.trig  <= TRIG_ONE << ch;
                        phase_cnt <= TRIG_LOAD;
                        slot_rem  <= SLOT_LOAD;
                    end else begin
                        phase_cnt <= phase_cnt - PW'(1);
                    end
                end
                TRIG: begin
                    if (phase_cnt == '0) begin
                        bus.trig <= '0;
                        state    <= WAIT_ECHO;
                    end else begin
                        phase_cnt <= phase_cnt - PW'(1);
                    end
                end
                WAIT_ECHO: begin
                    if (started)
                        state <= MEASURE;
                    else if (result_write)
                        state <= UPDATE;
                end
                MEASURE: begin
                    if (result_write)
                        state <= UPDATE;
                end
                UPDATE: begin
                    state <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (slot_rem == '0) begin
                        ch <= ch_next;
                        if (bus.enable) begin
                            state     <= TRIG;
                            bus.trig  <= TRIG_ONE << ch_next;
                            phase_cnt <= TRIG_LOAD;
                            slot_rem  <= SLOT_LOAD;
                        end else begin
                            state     <= IDLE;
                            phase_cnt <= STARTUP_LOAD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (result_write) begin
                bus.distance_out[int'(ch)*DIST_W +: DIST_W] <= res_dist;
                bus.op[ch]      <= res_op;
                bus.timeout[ch] <= timed_out;
                bus.meas_valid  <= 1'b1;
                bus.meas_ch     <= CH_IDX_MAX_W'(ch);
            end
        end
    end

endmodule

// File: tb/tb_multi_ultrasonic_ctrl.sv
module tb_multi_ultrasonic_ctrl;
    import multi_ultrasonic_pkg::*;

    localparam int NUM_CH  = 3;
    localparam int STARTUP = 50;
    localparam int TRIG_W  = 500;
    localparam int CPM     = 294;
    localparam int TMO     = 1500;
    localparam int SLOT    = 3600;

    logic clk_50M = 1'b0;
    logic reset   = 1'b1;
    always #10 clk_50M = ~clk_50M;

    multi_ultrasonic_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

    multi_ultrasonic_ctrl #(
        .NUM_CH              (NUM_CH),
        .STARTUP_CYCLES      (STARTUP),
        .TRIG_CYCLES         (TRIG_W),
        .CYCLES_PER_MM       (CPM),
        .ECHO_TIMEOUT_CYCLES (TMO),
        .SLOT_CYCLES         (SLOT)
    ) dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        int ch;
        int delay;      // cycles after trig fall before echo rises
        int width;      // echo high cycles; 0 = no echo
        bit pre_high;   // echo held high from before the trigger
        bit noise;      // toggle the other channels' echoes
        bit drop_en;    // drop enable during the trigger
        int thresh;
        int exp_dist;
        bit exp_op;
        bit exp_to;
    } vec_t;

    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   m_dist[NUM_CH];
    bit   m_op[NUM_CH];
    bit   m_to[NUM_CH];

    always @(posedge clk_50M) cyc++;

    initial begin
        #(150_000 * 20);
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 150000", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("%s_dist%0d", tag, c), 64'(bus.distance_out[c*16 +: 16]), 64'(m_dist[c]));
            check($sformatf("%s_op%0d", tag, c), 64'(bus.op[c]), 64'(m_op[c]));
            check($sformatf("%s_to%0d", tag, c), 64'(bus.timeout[c]), 64'(m_to[c]));
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < NUM_CH; c++) begin
            m_dist[c] = 0;
            m_op[c]   = 1'b0;
            m_to[c]   = 1'b0;
        end
    endtask

    task automatic wait_trig_rise(output int rc, output bit ok);
        ok = 1'b0;
        rc = 0;
        for (int i = 0; i < SLOT + 200; i++) begin
            @(posedge clk_50M); #1;
            if (bus.trig != '0) begin
                rc = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic trig_width(output int w);
        w = 1;
        for (int i = 0; i < TRIG_W + 100; i++) begin
            @(posedge clk_50M); #1;
            if (bus.trig == '0) return;
            w++;
        end
    endtask

    // One full slot: wait for the trigger, check its timing, drive the echo
    // and check the result against the per-channel model.
    task automatic run_slot(input string tag, input vec_t v, input int exp_rise, output int rc);
        bit   ok;
        bit   got;
        int   w;
        logic [NUM_CH-1:0] e;
        bus.obst_thresh_mm = 16'(v.thresh);
        if (v.pre_high) bus.echo_rx[v.ch] = 1'b1;
        wait_trig_rise(rc, ok);
        check({tag, "_trig_seen"}, 64'(ok), 64'(1));
        if (!ok) return;
        check({tag, "_trig_rise_cyc"}, 64'(rc), 64'(exp_rise));
        check({tag, "_trig_onehot"}, 64'(bus.trig), 64'(1) << v.ch);
        if (v.drop_en) bus.enable = 1'b0;
        trig_width(w);
        check({tag, "_trig_width"}, 64'(w), 64'(TRIG_W));
        got = 1'b0;
        for (int i = 0; i < 2 * TMO + 200; i++) begin
            @(posedge clk_50M); #1;
            if (bus.meas_valid) begin
                got = 1'b1;
                break;
            end
            e = '0;
            if (v.noise && (i % 37) < 20) e = '1;
            e[v.ch] = v.pre_high || (v.width > 0 && i >= v.delay && i < v.delay + v.width);
            bus.echo_rx = e;
        end
        bus.echo_rx = '0;
        check({tag, "_meas_valid_seen"}, 64'(got), 64'(1));
        if (!got) return;
        m_dist[v.ch] = v.exp_dist;
        m_op[v.ch]   = v.exp_op;
        m_to[v.ch]   = v.exp_to;
        check({tag, "_meas_ch"}, 64'(bus.meas_ch), 64'(v.ch));
        check_all(tag);
        @(posedge clk_50M); #1;
        check({tag, "_meas_valid_pulse"}, 64'(bus.meas_valid), 64'(0));
    endtask

    initial begin
        int   rel;
        int   rc;
        int   exp_rise;
        int   hi_cnt;
        bit   ok;
        vec_t v;

        //          ch dly width pre noi drp thr  dist op to
        vecs[0] = '{0, 5, 1000, 0, 0, 0, 200, 3, 1, 0};
        vecs[1] = '{1, 5, 0,    0, 0, 0, 200, 0, 0, 1};
        vecs[2] = '{2, 5, 2000, 0, 0, 0, 200, 0, 0, 1};
        vecs[3] = '{0, 5, 1400, 0, 0, 0, 2,   4, 0, 0};
        vecs[4] = '{1, 5, 293,  0, 0, 0, 200, 0, 0, 0};
        vecs[5] = '{2, 5, 0,    1, 0, 0, 200, 0, 0, 1};
        vecs[6] = '{0, 5, 294,  0, 0, 0, 1,   1, 1, 0};
        vecs[7] = '{1, 5, 1180, 0, 1, 0, 200, 4, 1, 0};

        clear_model();
        bus.enable         = 1'b1;
        bus.obst_thresh_mm = 16'd200;
        bus.echo_rx        = '0;

        repeat (3) @(posedge clk_50M);
        #1;
        check("rst_trig", 64'(bus.trig), 64'(0));
        check("rst_meas_valid", 64'(bus.meas_valid), 64'(0));
        check("rst_meas_ch", 64'(bus.meas_ch), 64'(0));
        check_all("rst");

        @(negedge clk_50M);
        reset = 1'b0;
        rel   = cyc;
        repeat (STARTUP - 1) @(posedge clk_50M);
        #1;
        check("trig_before_startup", 64'(bus.trig), 64'(0));

        exp_rise = rel + STARTUP;
        for (int k = 0; k < 8; k++) begin
            run_slot($sformatf("slot%0d", k), vecs[k], exp_rise, rc);
            exp_rise = rc + SLOT;
        end

        // enable dropped during ch2 trigger: slot completes, then no trigger
        v = '{2, 5, 600, 0, 0, 1, 200, 2, 1, 0};
        run_slot("drop_en", v, exp_rise, rc);
        hi_cnt = 0;
        for (int i = 0; i < SLOT + 300; i++) begin
            @(posedge clk_50M); #1;
            if (bus.trig != '0) hi_cnt++;
        end
        check("idle_no_trig", 64'(hi_cnt), 64'(0));

        // re-enable: startup again, pointer wrapped to ch0
        bus.enable = 1'b1;
        rel = cyc;
        wait_trig_rise(rc, ok);
        check("reen_trig_seen", 64'(ok), 64'(1));
        check("reen_rise_cyc", 64'(rc), 64'(rel + STARTUP));
        check("reen_onehot", 64'(bus.trig), 64'(1));

        // reset in the middle of a ch0 measurement
        repeat (TRIG_W + 10) @(posedge clk_50M);
        #1;
        bus.echo_rx = 3'b001;
        repeat (100) @(posedge clk_50M);
        #5;
        reset = 1'b1;
        #1;
        clear_model();
        check("mrst_trig", 64'(bus.trig), 64'(0));
        check("mrst_meas_valid", 64'(bus.meas_valid), 64'(0));
        check("mrst_meas_ch", 64'(bus.meas_ch), 64'(0));
        check_all("mrst");
        bus.echo_rx = '0;

        // restart, then reset while the trigger is high
        @(negedge clk_50M);
        reset = 1'b0;
        rel   = cyc;
        wait_trig_rise(rc, ok);
        check("rst2_rise_cyc", 64'(rc), 64'(rel + STARTUP));
        repeat (10) @(posedge clk_50M);
        #4;
        check("trig_high_before_rst", 64'(bus.trig), 64'(1));
        reset = 1'b1;
        #1;
        check("trig_async_drop", 64'(bus.trig), 64'(0));

        // clean restart and one measurement
        @(negedge clk_50M);
        reset = 1'b0;
        rel   = cyc;
        v = '{0, 5, 1000, 0, 0, 0, 200, 3, 1, 0};
        run_slot("restart", v, rel + STARTUP, rc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
